// File: rtl/kernel_kcore_start_fifo_bcast.sv
// kernel_kcore_start_fifo_bcast
// Start-token FIFO with one producer and NUM_CH broadcast consumers. Every
// written entry is read once by each channel at that channel's own pace, and
// its slot is reused only after the slowest channel has read it.
// Optional build macro: KCORE_START_FIFO_LEVEL_EN adds if_usedw and
// if_almost_full (occupancy and almost-full against AF_LEVEL).
module kernel_kcore_start_fifo_bcast #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2,
    parameter int AF_LEVEL   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         if_full_n,
    input  logic                         if_write_ce,
    input  logic                         if_write,
    input  logic [DATA_WIDTH-1:0]        if_din,
    output logic [NUM_CH-1:0]            if_empty_n,
    input  logic [NUM_CH-1:0]            if_read_ce,
    input  logic [NUM_CH-1:0]            if_read,
    output logic [NUM_CH*DATA_WIDTH-1:0] if_dout
`ifdef KCORE_START_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]          if_usedw,
    output logic                         if_almost_full
`endif
);

    // Counters hold 0..DEPTH, which always fits in ADDR_WIDTH+1 bits.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);

    // Circular pointer increment; wraps at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
        logic [ADDR_WIDTH-1:0] res;
        if (ptr == LAST_PTR) begin
            res = '0;
        end else begin
            res = ptr + ADDR_WIDTH'(1'b1);
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_r     [NUM_CH];
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s [NUM_CH];
    logic [CW-1:0]         cnt_r        [NUM_CH];
    logic [CW-1:0]         cnt_nxt_s    [NUM_CH];
    logic [CW-1:0]         occ_nxt_s;
    logic                  full_n_r;
    logic [NUM_CH-1:0]     empty_n_r;
    logic [NUM_CH-1:0]     empty_n_nxt_s;
    logic                  wr_fire_s;
    logic [NUM_CH-1:0]     rd_fire_s;

    // Handshake qualification; flags are registered so there is no input-to-output path.
    always_comb begin
        wr_fire_s = if_write & if_write_ce & full_n_r;
        rd_fire_s = if_read & if_read_ce & empty_n_r;
    end

    // Next pointers, per-channel counts and the slowest-channel occupancy.
    always_comb begin
        occ_nxt_s = '0;
        if (wr_fire_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_fire_s[c]) begin
                rd_ptr_nxt_s[c] = ptr_inc(rd_ptr_r[c]);
            end else begin
                rd_ptr_nxt_s[c] = rd_ptr_r[c];
            end
            case ({wr_fire_s, rd_fire_s[c]})
                2'b10:   cnt_nxt_s[c] = cnt_r[c] + CW'(1'b1);
                2'b01:   cnt_nxt_s[c] = cnt_r[c] - CW'(1'b1);
                default: cnt_nxt_s[c] = cnt_r[c];
            endcase
            empty_n_nxt_s[c] = (cnt_nxt_s[c] != '0);
            if (cnt_nxt_s[c] > occ_nxt_s) begin
                occ_nxt_s = cnt_nxt_s[c];
            end else begin
                occ_nxt_s = occ_nxt_s;
            end
        end
    end

    // Pointer, count and status-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            full_n_r  <= 1'b1;
            empty_n_r <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_r[c] <= '0;
                cnt_r[c]    <= '0;
            end
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            full_n_r  <= (occ_nxt_s < DEPTH_CNT);
            empty_n_r <= empty_n_nxt_s;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_r[c] <= rd_ptr_nxt_s[c];
                cnt_r[c]    <= cnt_nxt_s[c];
            end
        end
    end

    // Token storage; contents need no reset, writes in a reset cycle are discarded.
    always_ff @(posedge clk) begin
        if (wr_fire_s && !reset) begin
            mem_r[wr_ptr_r] <= if_din;
        end
    end

    assign if_full_n  = full_n_r;
    assign if_empty_n = empty_n_r;

    // Show-ahead: each channel sees the entry at its own read pointer.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_dout
        assign if_dout[c*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr_r[c]];
    end

`ifdef KCORE_START_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] usedw_r;
    logic                almost_full_r;

    // Occupancy and almost-full level, registered from the next-state occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            usedw_r       <= '0;
            almost_full_r <= (AF_LEVEL == 0);
        end else begin
            usedw_r       <= occ_nxt_s;
            almost_full_r <= (int'(occ_nxt_s) >= AF_LEVEL);
        end
    end

    assign if_usedw       = usedw_r;
    assign if_almost_full = almost_full_r;
`else
    // AF_LEVEL has no effect in this build; it is referenced here only.
    if (AF_LEVEL < 0) begin : g_af_level_unused
    end
`endif

endmodule

// File: doc/kernel_kcore_start_fifo_bcast.md
Name: kernel_kcore_start_fifo_bcast

Overview:
Parametrised start-token FIFO, one producer, NUM_CH consumers. Every written entry is broadcast: each consumer channel reads its own copy at its own pace. Sits between an HLS dataflow task and several downstream tasks that all need the same start/argument token. An entry is retired only after every channel has read it.

Parameters:
DATA_WIDTH, 1, token width in bits.
ADDR_WIDTH, 2, pointer width; DEPTH <= 2**ADDR_WIDTH.
DEPTH, 4, entries; legal range 2..2**ADDR_WIDTH.
NUM_CH, 2, consumer channels; legal range 1..8.
AF_LEVEL, 3, almost-full threshold; used only with the optional feature.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
if_full_n  out  1  1 = a write will be accepted.
if_write_ce  in  1  write clock-enable.
if_write  in  1  write request.
if_din  in  DATA_WIDTH  write data.
if_empty_n  out  NUM_CH  bit c = 1: channel c has an unread entry.
if_read_ce  in  NUM_CH  per-channel read clock-enable.
if_read  in  NUM_CH  per-channel read request.
if_dout  out  NUM_CH*DATA_WIDTH  channel c head entry at bits [c*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Storage: circular array of DEPTH entries; wr_ptr wraps DEPTH-1 -> 0; one rd_ptr[c] and one cnt[c] (0..DEPTH) per channel.
- Occupancy occ = max over c of cnt[c], i.e. entries not yet read by the slowest channel.
- Write accepted (wr_fire) when if_write & if_write_ce & if_full_n. Data goes to mem[wr_ptr]; wr_ptr advances. A write while if_full_n=0 is dropped, with no state change.
- Channel c read accepted (rd_fire[c]) when if_read[c] & if_read_ce[c] & if_empty_n[c]; rd_ptr[c] advances. A read while empty is ignored.
- cnt[c] update: +1 on wr_fire only; -1 on rd_fire[c] only; unchanged on both or neither.
- Channels are independent. Any subset of channels may read in the same cycle as a write.
- if_full_n = (occ < DEPTH), computed from registers only. Reads in the current cycle do not free a slot for a same-cycle write; no combinational input-to-output path.
- if_empty_n[c] = (cnt[c] != 0), from registers. A write at edge t makes if_empty_n high on all channels from t+1.
- if_dout slice c = mem[rd_ptr[c]] (show-ahead). It is valid whenever if_empty_n[c]=1 and holds until that channel reads.
- Latency: write to visible on every channel is 1 cycle. Read to next entry visible is 1 cycle.
- Full boundary: the slowest channel with cnt=DEPTH blocks the writer even if other channels are empty. if_full_n rises the cycle after that channel reads.
- Wrap: pointers wrap modulo DEPTH, including non-power-of-2 DEPTH (e.g. 3 with ADDR_WIDTH=2).
- Reset (also mid-operation): wr_ptr=0, all rd_ptr=0, all cnt=0. Outputs: if_full_n=1, if_empty_n=0 on all channels, if_dout don't-care. Any fire in the reset cycle is discarded.
- NUM_CH=1 with DEPTH=2**ADDR_WIDTH behaves as a plain single-consumer FIFO with identical handshake timing.
- Memory contents need no reset.

Optional Feature:
KCORE_START_FIFO_LEVEL_EN:
- Defined: adds output ports if_usedw (ADDR_WIDTH+1 bits) = occ, and if_almost_full (1 bit) = (occ >= AF_LEVEL). Both are registered-derived; reset values are 0 and (AF_LEVEL==0).
- Undefined: neither port exists; AF_LEVEL is ignored; core behaviour is identical.

Test Plan:
1. DEPTH=4, NUM_CH=2. Write 0,1 on consecutive cycles, no reads -> if_empty_n=2'b11 from the cycle after the first write; both if_dout slices show 0.
2. Write 4 tokens A..D; ch0 reads all 4, ch1 reads none -> if_full_n=0. A 5th write E is dropped; ch1 then reads A -> if_full_n=1 one cycle later; E is written, and ch1 later reads B,C,D,E.
3. DEPTH=4, one entry outstanding on ch0 and ch1. Write and both reads in the same cycle -> cnt stays 1 per channel; the new token appears on both channels next cycle.
4. DEPTH=3, ADDR_WIDTH=2, NUM_CH=1. Stream 10 tokens 0..9 with continuous read -> output order 0..9; wr_ptr wraps 2->0 with no loss or duplicate.
5. Reset asserted with 3 entries pending on both channels and write+read active -> next cycle if_full_n=1, if_empty_n=0; a write after reset is visible one cycle later.
6. With KCORE_START_FIFO_LEVEL_EN, AF_LEVEL=3. Write 3 tokens, no reads -> if_usedw=3 and if_almost_full=1 the cycle after the 3rd write; one read on each channel -> if_usedw=2, if_almost_full=0.
